// File: rtl/fifo_playback_reader.sv
// fifo_playback_reader
//   Reads one sample per sample-rate tick from the playback FIFO, scales it by
//   an unsigned Q1.(GAIN_W-1) gain and presents it to the output stage with a
//   one-cycle valid strobe. FIFO occupancy is tracked locally by watching the
//   writer's wr line, so an empty FIFO produces silence plus a sticky underrun
//   flag instead of stale data.
//
//   Optional build macro FIFO_READER_SAT_EN: when defined, scaled results
//   outside the signed WIDTH range clamp to the nearest extreme; when
//   undefined, results wrap to their low WIDTH bits.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   enable       playback enable (gates the tick divider)
//   clear_flags  synchronous clear of underrun/overflow (a same-cycle set wins)
//   wr_mon       copy of the FIFO's wr input
//   fifo_rd      FIFO read strobe; rising edge advances the FIFO read pointer
//   fifo_dout    FIFO head data
//   gain         volume, sampled in SCALE
//   sample_out   scaled sample, signed
//   sample_valid one-cycle strobe marking a new sample_out
//   level        number of readable FIFO entries
//   underrun     sticky: a tick arrived with level == 0
//   overflow     sticky: a write was seen with level == DEPTH
module fifo_playback_reader #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 512,
  parameter int CLK_HZ    = 100_000_000,
  parameter int SAMPLE_HZ = 48000,
  parameter int GAIN_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         clear_flags,
  input  logic                         wr_mon,
  output logic                         fifo_rd,
  input  logic [WIDTH-1:0]             fifo_dout,
  input  logic [GAIN_W-1:0]            gain,
  output logic [WIDTH-1:0]             sample_out,
  output logic                         sample_valid,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         underrun,
  output logic                         overflow
);

  localparam int DIV    = CLK_HZ / SAMPLE_HZ;
  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int PROD_W = WIDTH + GAIN_W + 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CHECK   = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] RELEASE = 3'd3;
  localparam logic [2:0] SCALE   = 3'd4;
  localparam logic [2:0] OUT     = 3'd5;

  logic [2:0]       state;
  logic [CNT_W-1:0] div_cnt;
  logic             tick;
  logic             wr_mon_prev;
  logic [2:0]       wr_dly;
  logic             wr_settled;
  logic             rd_dec;
  logic             empty_hit;
  logic [WIDTH-1:0] sample_reg;
  logic             und_set;
  logic             ovf_set;

  logic signed [PROD_W-1:0] samp_ext;
  logic signed [PROD_W-1:0] gain_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] shifted;
  logic [WIDTH-1:0]         result;

  // ---------------------------------------------------------------- divider
  assign tick = enable && (div_cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!enable || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  // --------------------------------------------------------- write tracking
  // A write edge is only counted three cycles later, once the FIFO's RAM
  // write has settled and the head is safe to capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_mon_prev <= 1'b0;
      wr_dly      <= '0;
    end else begin
      wr_mon_prev <= wr_mon;
      wr_dly      <= {wr_dly[1:0], wr_mon & ~wr_mon_prev};
    end
  end

  assign wr_settled = wr_dly[2];
  assign rd_dec     = (state == RELEASE) && !empty_hit;

  // A settled write and a read in the same cycle cancel, so a full FIFO
  // being drained and refilled at once is not an overflow.
  assign ovf_set = wr_settled && !rd_dec && (level == LVL_W'(DEPTH));
  assign und_set = (state == CHECK) && (level == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else begin
      case ({wr_settled, rd_dec})
        2'b10:   if (level != LVL_W'(DEPTH)) level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      underrun <= und_set | (underrun & ~clear_flags);
      overflow <= ovf_set | (overflow & ~clear_flags);
    end
  end

  // -------------------------------------------------------------- scaling
  assign samp_ext = {{(GAIN_W + 1){sample_reg[WIDTH-1]}}, sample_reg};
  assign gain_ext = {{(WIDTH + 1){1'b0}}, gain};
  assign prod     = samp_ext * gain_ext;
  assign shifted  = prod >>> (GAIN_W - 1);

`ifdef FIFO_READER_SAT_EN
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    result = WIDTH'(shifted);
    if (shifted > SAT_MAX) begin
      result = WIDTH'(SAT_MAX);
    end else if (shifted < SAT_MIN) begin
      result = WIDTH'(SAT_MIN);
    end
  end
`else
  assign result = WIDTH'(shifted);
`endif

  // ------------------------------------------------------------------ FSM
  // Strobes are decoded straight from registered state so they are
  // glitch-free; sample_out is loaded on the SCALE->OUT edge so it is
  // already stable while sample_valid is high in OUT.
  assign fifo_rd      = (state == CAPTURE) && !empty_hit;
  assign sample_valid = (state == OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      empty_hit  <= 1'b0;
      sample_reg <= '0;
      sample_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) state <= CHECK;
        end
        CHECK: begin
          empty_hit <= (level == '0);
          state     <= CAPTURE;
        end
        CAPTURE: begin
          sample_reg <= empty_hit ? '0 : fifo_dout;
          state      <= RELEASE;
        end
        RELEASE: begin
          state <= SCALE;
        end
        SCALE: begin
          sample_out <= result;
          state      <= OUT;
        end
        OUT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_playback_reader.sv
// Testbench for fifo_playback_reader. Emulates the attached FIFO, drives
// writes and gains, predicts every output sample from an arithmetic model of
// the scaling rules and checks sample timing, data, level and sticky flags.
module tb_fifo_playback_reader;

  localparam int W    = 16;
  localparam int D    = 8;
  localparam int GW   = 8;
  localparam int DIVT = 20;
  localparam int LW   = $clog2(D + 1);

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          clear_flags;
  logic          wr_mon;
  logic          fifo_rd;
  logic [W-1:0]  fifo_dout;
  logic [GW-1:0] gain;
  logic [W-1:0]  sample_out;
  logic          sample_valid;
  logic [LW-1:0] level;
  logic          underrun;
  logic          overflow;
  logic [W-1:0]  wr_data;

  fifo_playback_reader #(
    .WIDTH(W),
    .DEPTH(D),
    .CLK_HZ(960_000),
    .SAMPLE_HZ(48_000),
    .GAIN_W(GW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .clear_flags(clear_flags),
    .wr_mon(wr_mon),
    .fifo_rd(fifo_rd),
    .fifo_dout(fifo_dout),
    .gain(gain),
    .sample_out(sample_out),
    .sample_valid(sample_valid),
    .level(level),
    .underrun(underrun),
    .overflow(overflow)
  );

  typedef struct {
    int           cyc;
    logic [W-1:0] val;
  } exp_t;

  exp_t         expq[$];
  logic [W-1:0] mq[$];
  logic [W-1:0] wq[$];
  logic [W-1:0] hwq[$];
  bit           m_und;
  bit           m_ovf;
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           tprev;
  int           tnext;
  int           exp_reads = 0;
  int           rd_pulses = 0;
  logic [W-1:0] last_val;
  logic         rd_seen_prev = 1'b0;
  logic         wr_q;
  logic         rd_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Attached FIFO: edge-triggered write and read, head on fifo_dout.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwq.delete();
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      fifo_dout <= '0;
    end else begin
      if (fifo_rd && !rd_q && hwq.size() != 0) void'(hwq.pop_front());
      if (wr_mon && !wr_q && hwq.size() < D) hwq.push_back(wr_data);
      wr_q      <= wr_mon;
      rd_q      <= fifo_rd;
      fifo_dout <= (hwq.size() != 0) ? hwq[0] : '0;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT strobes a sample.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sample_valid) begin
        if (expq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_valid @cyc %0d: got %h expected none", cyc, sample_out);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("valid_cycle", cyc, e.cyc);
          chk("sample", sample_out, e.val);
        end
      end else if (expq.size() != 0 && cyc > expq[0].cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL valid_timeout @cyc %0d: got no valid expected at %0d", cyc, expq[0].cyc);
        void'(expq.pop_front());
      end
      if (fifo_rd) begin
        rd_pulses++;
        chk("rd_single_cycle", rd_seen_prev, 0);
      end
      rd_seen_prev = fifo_rd;
    end else begin
      rd_seen_prev = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference scaling: floor(sample * gain / unity), then clamp or wrap.
  function automatic logic [W-1:0] scale(input logic [W-1:0] s, input logic [GW-1:0] g);
    int p;
    int r;
    int unity;
    unity = 1 << (GW - 1);
    p = int'($signed(s)) * int'(g);
    if (p >= 0) r = p / unity;
    else        r = -((-p + unity - 1) / unity);
`ifdef FIFO_READER_SAT_EN
    if (r > (1 << (W - 1)) - 1) r = (1 << (W - 1)) - 1;
    if (r < -(1 << (W - 1)))    r = -(1 << (W - 1));
`endif
    return r[W-1:0];
  endfunction

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_write(input logic [W-1:0] d);
    wr_data = d;
    wr_mon  = 1'b1;
    if (mq.size() < D) mq.push_back(d);
    else               m_ovf = 1'b1;
    @(negedge clk);
    wr_mon = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_phase();
    enable = 1'b1;
    tnext  = cyc + DIVT - 1;
    tprev  = cyc - DIVT;
  endtask

  task automatic end_phase();
    wait_cyc(tprev + 2);
    enable = 1'b0;
    wait_cyc(tprev + 9);
    chk("hold_out", sample_out, last_val);
  endtask

  // One sample period: optional clear, queued writes, pre-tick state checks,
  // then the tick itself with an optional write landing on RELEASE.
  task automatic period(input logic [GW-1:0] g, input bit late, input logic [W-1:0] late_d,
                        input bit clr_pre, input bit clr_chk);
    exp_t         e;
    logic [W-1:0] v;
    bit           lt;
    bit           was_empty;
    wait_cyc(tprev + 7);
    gain = g;
    if (clr_pre) begin
      clear_flags = 1'b1;
      @(negedge clk);
      clear_flags = 1'b0;
      m_und = 1'b0;
      m_ovf = 1'b0;
    end
    while (wq.size() != 0) do_write(wq.pop_front());
    wait_cyc(tnext - 1);
    chk("level", level, mq.size());
    chk("underrun", underrun, m_und);
    chk("overflow", overflow, m_ovf);
    wait_cyc(tnext);
    lt = late && (mq.size() < D);
    if (lt) begin
      wr_data = late_d;
      wr_mon  = 1'b1;
    end
    was_empty = (mq.size() == 0);
    if (!was_empty) begin
      v = scale(mq.pop_front(), g);
      exp_reads++;
    end else begin
      v = '0;
      m_und = 1'b1;
    end
    e.cyc = tnext + 5;
    e.val = v;
    expq.push_back(e);
    last_val = v;
    @(negedge clk);
    wr_mon = 1'b0;
    if (lt) mq.push_back(late_d);
    if (clr_chk) begin
      clear_flags = 1'b1;
      m_ovf = 1'b0;
      if (!was_empty) m_und = 1'b0;
      @(negedge clk);
      clear_flags = 1'b0;
    end
    tprev = tnext;
    tnext = tnext + DIVT;
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    clear_flags = 1'b0;
    wr_mon = 1'b0;
    wr_data = '0;
    gain = '0;
    m_und = 1'b0;
    m_ovf = 1'b0;
    last_val = '0;
    repeat (3) @(negedge clk);
    chk("rst_sample_out", sample_out, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_level", level, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed: pass-through, drain to empty, gain corners, RELEASE overlap.
    start_phase();
    wq = '{16'h0123, 16'h7FFF, 16'h8000};
    period(8'd128, 0, '0, 0, 0);
    period(8'd128, 0, '0, 0, 0);
    period(8'd128, 0, '0, 0, 0);
    period(8'd128, 0, '0, 0, 0);
    wq = '{16'h1000};
    period(8'd64, 0, '0, 0, 0);
    wq = '{16'h6000};
    period(8'd255, 0, '0, 0, 0);
    wq = '{16'h8000};
    period(8'd255, 0, '0, 0, 0);
    wq = '{16'h0042};
    period(8'd128, 1, 16'h0055, 1, 0);
    period(8'd128, 0, '0, 0, 0);
    period(8'd100, 0, '0, 0, 1);
    end_phase();

    // Overflow: DEPTH+1 writes with playback stopped, then clear.
    for (int i = 0; i < D + 1; i++) do_write(W'($urandom));
    repeat (6) @(negedge clk);
    chk("ovf_level", level, D);
    chk("ovf_flag", overflow, 1);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    m_ovf = 1'b0;
    m_und = 1'b0;
    @(negedge clk);
    chk("clr_overflow", overflow, 0);
    chk("clr_level", level, D);

    // Randomized phases.
    for (int ph = 0; ph < 3; ph++) begin
      start_phase();
      for (int p = 0; p < 6; p++) begin
        int nw;
        nw = $urandom_range(0, 2);
        for (int k = 0; k < nw; k++) wq.push_back(W'($urandom));
        period(GW'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), W'($urandom),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
      end
      end_phase();
    end

    // Reset asserted while a read is in CAPTURE.
    do_write(16'h1357);
    repeat (4) @(negedge clk);
    start_phase();
    wait_cyc(tnext + 2);
    chk("rd_in_capture", fifo_rd, 1);
    exp_reads++;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_fifo_rd", fifo_rd, 0);
    chk("arst_sample_out", sample_out, 0);
    chk("arst_sample_valid", sample_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_underrun", underrun, 0);
    chk("arst_overflow", overflow, 0);
    mq.delete();
    m_und = 1'b0;
    m_ovf = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // FSM restarts cleanly after the abandoned read.
    start_phase();
    wq = '{16'h2222};
    period(8'd128, 0, '0, 0, 0);
    end_phase();

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", expq.size(), 0);
    chk("rd_pulses", rd_pulses, exp_reads);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_playback_reader.md
Name: fifo_playback_reader

Overview:
- Downstream consumer of the sample FIFO in the playback path.
- Generates a sample-rate tick and reads one sample per tick from the FIFO's edge-triggered read interface.
- Applies a fixed-point gain and presents the scaled sample with a one-cycle valid strobe to the DAC/output stage.
- Tracks FIFO occupancy by monitoring the writer's wr line, so an empty FIFO yields silence and an underrun flag instead of stale data.

Parameters:
- WIDTH, 16: sample width, signed two's complement.
- DEPTH, 512: FIFO depth; must match the attached FIFO.
- CLK_HZ, 100_000_000: clk frequency.
- SAMPLE_HZ, 48000: output sample rate. Divider DIV = CLK_HZ/SAMPLE_HZ, integer floor, 2083 at defaults.
- GAIN_W, 8: gain width, unsigned Q1.(GAIN_W-1); 128 = unity at default.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset; asynchronous, active-low. Single clock domain (clk only).
- enable  in  1  playback enable.
- clear_flags  in  1  synchronous clear of sticky flags.
- wr_mon  in  1  copy of the FIFO's wr input.
- fifo_rd  out  1  to FIFO rd; rising edge advances the read pointer.
- fifo_dout  in  WIDTH  FIFO head data.
- gain  in  GAIN_W  volume, sampled in SCALE.
- sample_out  out  WIDTH  scaled sample, signed.
- sample_valid  out  1  one-cycle strobe on each new sample_out.
- level  out  $clog2(DEPTH+1)  readable entries.
- underrun  out  1  sticky: tick arrived with level==0.
- overflow  out  1  sticky: write seen with level==DEPTH.

Behaviour:
Reset (asynchronous, rst_n low):
- All outputs 0, divider 0, FSM IDLE.
- Applies immediately, including mid-operation; an in-flight read is abandoned.

Tick divider:
- Counts 0..DIV-1 while enable=1; tick asserted for one cycle when count==DIV-1.
- Held at 0 while enable=0.

Write tracking:
- wr_edge = wr_mon & ~wr_mon_prev.
- wr_edge passes through a 3-stage delay, so a new entry is counted only after the BRAM write has settled.
- A delayed edge increments level.
- If level==DEPTH: level holds and overflow is set.

FSM (states IDLE, CHECK, CAPTURE, RELEASE, SCALE, OUT):
- IDLE: on tick, go to CHECK. Ticks arriving while not in IDLE are dropped (cannot occur since DIV > 5).
- CHECK: latch empty_hit = (level==0). If empty_hit, set underrun.
- CAPTURE: if !empty_hit, sample_reg <= fifo_dout and fifo_rd=1; else sample_reg <= 0 and fifo_rd stays 0.
- RELEASE: fifo_rd=0. If !empty_hit, level decrements.
- SCALE: prod = sample_reg * {1'b0,gain}, width WIDTH+GAIN_W+1; result = prod >>> (GAIN_W-1), arithmetic shift (floor).
- OUT: sample_out <= result, sample_valid=1 for this cycle only, then IDLE.

Timing and handshake:
- fifo_rd is decoded from the state register (glitch-free), high exactly one cycle, low at least 4 cycles between pulses.
- Head data is captured before advancing; the FIFO pointer always settles more than 2 cycles before the next capture.
- Latency: tick at cycle T gives sample_valid at T+5, identical on the underrun path.

Boundary conditions:
- Simultaneous delayed wr edge and RELEASE decrement: level unchanged.
- Delayed wr edge at level==DEPTH in the same cycle as a decrement: level unchanged, no overflow.
- enable deasserted mid-read: the current sequence completes; sample_out holds its last value.
- clear_flags clears underrun and overflow. If a set and a clear occur in the same cycle, set wins.

Optional Feature:
- Macro: FIFO_READER_SAT_EN.
- Defined: a result outside the signed WIDTH range clamps to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
- Undefined: result is truncated to its low WIDTH bits (wraps).
- At gain ≤ unity both builds are identical.

Test Plan:
- Assert rst_n low during CAPTURE -> fifo_rd, sample_out, sample_valid, level, underrun, overflow all 0 without waiting for a clk edge; FSM restarts in IDLE.
- 3 writes of 0x0123, 0x7FFF, 0x8000 at gain=128 -> three sample_valid pulses, each at tick+5, with equal values in order. Exactly three single-cycle fifo_rd pulses; level goes 3->2->1->0.
- level=0, tick -> sample_out=0x0000 with sample_valid, underrun=1, no fifo_rd pulse.
- Gain check: head 0x1000, gain=64 -> 0x0800. Head 0x6000, gain=255 -> 0x7FFF with FIFO_READER_SAT_EN, 0xBF40 without. Head 0x8000, gain=255 -> 0x8000 with SAT_EN.
- Delayed wr edge coinciding with RELEASE at level=1 -> level stays 1.
- DEPTH+1 write edges with no reads -> level=512, overflow=1; pulse clear_flags -> overflow=0, level still 512.
